// File: rtl/npu_pkg.sv
// Shared types for the NPU read path: scheduler states and the buffered result entry.
package npu_pkg;
    localparam int NPU_NUM_CH = 8;
    localparam int NPU_DW     = 16;
    localparam int NPU_CHW    = $clog2(NPU_NUM_CH);

    typedef enum logic [2:0] {
        IDLE, SELECT, SPACE, ISSUE, COLLECT, FLUSH, DRAIN, DONE
    } sched_state_t;

    typedef struct packed {
        logic [NPU_DW-1:0]  data;
        logic [NPU_CHW-1:0] ch;
        logic               first;
        logic               last;
    } rd_entry_t;
endpackage

// File: rtl/npu_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output and an occupancy count.
module npu_sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 16,
    parameter int  CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              push_data,
    output logic          full,
    input  logic          pop,
    output T              pop_data,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is not reset; the count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/npu_rd_sched.sv
// Read-side scheduler: walks enabled result channels in ascending order and merges
// their bursts into one tagged valid/ready stream, admitting a burst only when it fits.
module npu_rd_sched
    import npu_pkg::*;
#(
    parameter int NUM_CH     = NPU_NUM_CH,
    parameter int DW         = NPU_DW,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      save_finish,
    input  logic [NUM_CH-1:0]         ch_en,
    output logic [NUM_CH-1:0]         rd_sop,
    input  logic [NUM_CH-1:0]         rd_vld,
    input  logic [NUM_CH-1:0]         rd_eop,
    input  logic [NUM_CH*DW-1:0]      rd_data,
    output logic                      m_vld,
    input  logic                      m_rdy,
    output logic [DW-1:0]             m_data,
    output logic [$clog2(NUM_CH)-1:0] m_ch,
    output logic                      m_sop,
    output logic                      m_eop,
    output logic                      busy,
    output logic                      done,
    output logic                      err_timeout,
    output logic                      err_ovf
);
    localparam int CHW = $clog2(NUM_CH);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    sched_state_t    state, next_state;
    logic            sf_q;
    logic            start;
    logic [NUM_CH-1:0] en_q, served, remain;
    logic [CHW-1:0]  cur, next_ch;
    logic [TW-1:0]   timer;
    rd_entry_t       pend, push_entry, fifo_out;
    logic            pend_vld, seen;
    logic            cur_vld, cur_eop;
    logic [DW-1:0]   cur_data;
    logic            timed_out, push;
    logic            fifo_full, fifo_empty;
    logic [FCW-1:0]  fifo_count;

    assign start     = save_finish && !sf_q;
    assign remain    = en_q & ~served;
    assign cur_vld   = rd_vld[cur];
    assign cur_eop   = rd_eop[cur];
    assign cur_data  = rd_data[int'(cur)*DW +: DW];
    assign timed_out = (state == COLLECT) && !cur_eop && (timer == TW'(TIMEOUT));

    always_comb begin
        next_ch = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (remain[c]) next_ch = CHW'(c);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SELECT;
            SELECT:  next_state = (remain == '0) ? DRAIN : SPACE;
            SPACE:   if ((FIFO_DEPTH - int'(fifo_count)) >= BURST_LEN) next_state = ISSUE;
            ISSUE:   next_state = COLLECT;
            COLLECT: if (cur_eop || timer == TW'(TIMEOUT)) next_state = FLUSH;
            FLUSH:   next_state = SELECT;
            DRAIN:   if (fifo_empty) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A new word displaces the pending one as non-last; FLUSH releases it as last.
    always_comb begin
        push            = 1'b0;
        push_entry      = pend;
        push_entry.last = 1'b0;
        if (state == COLLECT && cur_vld && pend_vld) push = 1'b1;
        if (state == FLUSH && pend_vld) begin
            push            = 1'b1;
            push_entry.last = 1'b1;
        end
    end

    always_comb begin
        rd_sop = '0;
        if (state == ISSUE && !rst) rd_sop[cur] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sf_q        <= 1'b0;
            en_q        <= '0;
            served      <= '0;
            cur         <= '0;
            timer       <= '0;
            pend        <= '0;
            pend_vld    <= 1'b0;
            seen        <= 1'b0;
            err_timeout <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            state <= next_state;
            sf_q  <= save_finish;
            if (state == IDLE && start) begin
                en_q   <= ch_en;
                served <= '0;
            end
            if (state == SELECT) cur <= next_ch;
            if (state == ISSUE) begin
                timer    <= '0;
                seen     <= 1'b0;
                pend_vld <= 1'b0;
            end
            if (state == COLLECT) begin
                timer <= timer + 1'b1;
                if (cur_vld) begin
                    pend.data  <= cur_data;
                    pend.ch    <= cur;
                    pend.first <= !seen;
                    pend.last  <= 1'b0;
                    pend_vld   <= 1'b1;
                    seen       <= 1'b1;
                end
            end
            if (state == FLUSH) begin
                served[cur] <= 1'b1;
                pend_vld    <= 1'b0;
            end
            if (timed_out) err_timeout <= 1'b1;
            if (push && fifo_full) err_ovf <= 1'b1;
        end
    end

    npu_sync_fifo #(
        .T     (rd_entry_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .full      (fifo_full),
        .pop       (m_vld && m_rdy),
        .pop_data  (fifo_out),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Payload is zeroed when idle so the stream reads all-zero out of reset.
    assign m_vld  = !fifo_empty;
    assign m_data = m_vld ? fifo_out.data  : '0;
    assign m_ch   = m_vld ? fifo_out.ch    : '0;
    assign m_sop  = m_vld ? fifo_out.first : 1'b0;
    assign m_eop  = m_vld ? fifo_out.last  : 1'b0;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
endmodule

// File: tb/tb_npu_rd_sched.sv
// Bench for npu_rd_sched: channel responder, output scoreboard and scenario tasks.
module tb_npu_rd_sched;
    localparam int NUM_CH = 8, DW = 16, BURST_LEN = 16, FIFO_DEPTH = 16, TIMEOUT = 20;

    logic              clk = 1'b0;
    logic              rst, save_finish;
    logic [7:0]        ch_en, rd_sop, rd_vld, rd_eop;
    logic [127:0]      rd_data;
    logic              m_vld, m_rdy, m_sop, m_eop, busy, done, err_timeout, err_ovf;
    logic [15:0]       m_data;
    logic [2:0]        m_ch;

    npu_rd_sched #(
        .NUM_CH(NUM_CH), .DW(DW), .BURST_LEN(BURST_LEN),
        .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .save_finish(save_finish), .ch_en(ch_en),
        .rd_sop(rd_sop), .rd_vld(rd_vld), .rd_eop(rd_eop), .rd_data(rd_data),
        .m_vld(m_vld), .m_rdy(m_rdy), .m_data(m_data), .m_ch(m_ch),
        .m_sop(m_sop), .m_eop(m_eop), .busy(busy), .done(done),
        .err_timeout(err_timeout), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    int          n_checks = 0, n_pass = 0;
    int          cyc = 0;
    logic [20:0] exp_q[$];
    int          n_words[8], eop_mode[8];
    logic [15:0] wdata[8][16];
    int          gap_max = 0, rdy_mode = 0, rdy_cnt = 0;
    bit          noise = 0, sb_en = 1, resp_abort = 0;
    int          sent_total = 0, popped_total = 0;
    int          sop_sig = 0, sop_cnt = 0, sop_cyc[8];
    int          done_cnt = 0, to_cyc = 0;
    bit          to_seen = 0, hold_pend = 0;
    logic [20:0] hold_val, obs, exp_item;

    initial forever @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Reference model: enabled channels in ascending order, first word sop, last word eop.
    function automatic int exp_sig(input logic [7:0] mask);
        int s = 0;
        for (int c = 0; c < 8; c++) if (mask[c]) s = s * 9 + c + 1;
        return s;
    endfunction

    task automatic build_expect(input logic [7:0] mask);
        for (int c = 0; c < 8; c++)
            if (mask[c])
                for (int i = 0; i < n_words[c]; i++)
                    exp_q.push_back({3'(c), wdata[c][i], (i == 0), (i == n_words[c] - 1)});
    endtask

    task automatic program_ch(input int c, input int n, input int mode, input bit rnd);
        n_words[c]  = n;
        eop_mode[c] = mode;
        for (int i = 0; i < 16; i++) wdata[c][i] = rnd ? 16'($urandom_range(0, 65535)) : 16'(c * 16 + i);
    endtask

    task automatic clear_pass;
        exp_q.delete();
        sop_sig  = 0;
        sop_cnt  = 0;
        done_cnt = 0;
        to_seen  = 0;
    endtask

    // Responder: serves one channel burst per observed rd_sop.
    task automatic drive_burst(input int c);
        int n = n_words[c];
        int g;
        int o = (c + 1) % 8;
        @(negedge clk);
        if (resp_abort) return;
        for (int i = 0; i < n; i++) begin
            g = $urandom_range(0, gap_max);
            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                if (resp_abort) return;
            end
            rd_vld[c] = 1'b1;
            rd_eop[c] = (eop_mode[c] == 0 && i == n - 1);
            rd_data[c*DW +: DW] = wdata[c][i];
            if (noise) begin
                rd_vld[o] = 1'b1;
                rd_eop[o] = 1'b1;
                rd_data[o*DW +: DW] = 16'($urandom_range(0, 65535));
            end
            sent_total++;
            @(negedge clk);
            rd_vld = '0;
            rd_eop = '0;
            if (resp_abort) return;
        end
        if (eop_mode[c] == 1 || (eop_mode[c] == 0 && n == 0)) begin
            rd_eop[c] = 1'b1;
            @(negedge clk);
            rd_eop[c] = 1'b0;
        end
    endtask

    initial begin
        int rc;
        rd_vld  = '0;
        rd_eop  = '0;
        rd_data = '0;
        forever begin
            @(negedge clk);
            if (rd_sop != '0 && !resp_abort) begin
                rc = 0;
                for (int k = 7; k >= 0; k--) if (rd_sop[k]) rc = k;
                n_checks++;
                if (!$onehot(rd_sop)) $display("FAIL sop_onehot: rd_sop=%b", rd_sop);
                else n_pass++;
                n_checks++;
                if (sent_total - popped_total > FIFO_DEPTH - BURST_LEN)
                    $display("FAIL sop_space: outstanding=%0d allowed=%0d", sent_total - popped_total, FIFO_DEPTH - BURST_LEN);
                else n_pass++;
                sop_sig = sop_sig * 9 + rc + 1;
                sop_cnt++;
                sop_cyc[rc] = cyc;
                drive_burst(rc);
            end
        end
    end

    // Scoreboard: ready driver, stream compare and hold-stable check.
    initial begin
        m_rdy = 1'b0;
        forever begin
            @(negedge clk);
            rdy_cnt++;
            case (rdy_mode)
                0:       m_rdy = 1'b1;
                1:       m_rdy = (rdy_cnt % 4 == 0);
                default: m_rdy = 1'($urandom_range(0, 1));
            endcase
            obs = {m_ch, m_data, m_sop, m_eop};
            if (!sb_en) hold_pend = 0;
            else begin
                if (hold_pend) begin
                    n_checks++;
                    if (m_vld !== 1'b1 || obs !== hold_val)
                        $display("FAIL hold_stable: got vld=%b %h, need vld=1 %h", m_vld, obs, hold_val);
                    else n_pass++;
                end
                hold_pend = m_vld && !m_rdy;
                hold_val  = obs;
                if (m_vld && m_rdy) begin
                    popped_total++;
                    n_checks++;
                    if (exp_q.size() == 0) $display("FAIL stream: got %h, need nothing", obs);
                    else begin
                        exp_item = exp_q.pop_front();
                        if (obs !== exp_item) $display("FAIL stream: got %h, need %h", obs, exp_item);
                        else n_pass++;
                    end
                end
            end
            if (done) done_cnt++;
            if (err_timeout && !to_seen) begin
                to_seen = 1;
                to_cyc  = cyc;
            end
        end
    end

    task automatic run_pass(input logic [7:0] mask, input int repulse_at, output bit ok);
        ch_en = mask;
        @(negedge clk) save_finish = 1'b1;
        @(negedge clk) save_finish = 1'b0;
        ok = 0;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            save_finish = (k == repulse_at);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        save_finish = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_pass(input string name, input logic [7:0] mask, input bit ok, input bit want_to);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL %s_finish: busy still 1, need 0", name); else n_pass++;
        n_checks++;
        if (done_cnt !== 1) $display("FAIL %s_done: got %0d pulses, need 1", name, done_cnt); else n_pass++;
        n_checks++;
        if (sop_sig !== exp_sig(mask)) $display("FAIL %s_order: got %0d, need %0d", name, sop_sig, exp_sig(mask)); else n_pass++;
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL %s_missing: got %0d left, need 0", name, exp_q.size()); else n_pass++;
        n_checks++;
        if ({err_timeout, err_ovf} !== {want_to, 1'b0})
            $display("FAIL %s_err: got to=%b ovf=%b, need to=%b ovf=0", name, err_timeout, err_ovf, want_to);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        save_finish = 1'b0;
        ch_en = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rd_sop, m_vld, busy, done, err_timeout, err_ovf} !== '0)
            $display("FAIL reset_ctrl: got %b, need 0", {rd_sop, m_vld, busy, done, err_timeout, err_ovf});
        else n_pass++;
        n_checks++;
        if ({m_data, m_ch, m_sop, m_eop} !== '0) $display("FAIL reset_data: got %h, need 0", {m_data, m_ch, m_sop, m_eop});
        else n_pass++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, rd_sop} !== '0) $display("FAIL reset_idle: got %b, need 0", {busy, rd_sop}); else n_pass++;
    endtask

    task automatic test_all_channels;
        bit ok;
        for (int c = 0; c < 8; c++) program_ch(c, 4, 0, 0);
        clear_pass();
        build_expect(8'hFF);
        run_pass(8'hFF, 10, ok);
        check_pass("all_ch", 8'hFF, ok, 0);
        n_checks++;
        if (sop_cnt !== 8) $display("FAIL all_ch_sop_count: got %0d, need 8", sop_cnt); else n_pass++;
    endtask

    task automatic test_sparse_mask;
        bit ok;
        for (int c = 0; c < 8; c++) program_ch(c, 4, 0, 1);
        clear_pass();
        build_expect(8'hA0);
        run_pass(8'hA0, -1, ok);
        check_pass("mask_a0", 8'hA0, ok, 0);
        clear_pass();
        run_pass(8'h00, -1, ok);
        check_pass("mask_00", 8'h00, ok, 0);
    endtask

    task automatic test_backpressure;
        bit ok;
        rdy_mode = 1;
        for (int c = 0; c < 8; c++) program_ch(c, 16, 0, 1);
        clear_pass();
        build_expect(8'hFF);
        run_pass(8'hFF, -1, ok);
        check_pass("backpressure", 8'hFF, ok, 0);
        rdy_mode = 0;
    endtask

    task automatic test_eop_timing;
        bit ok;
        program_ch(2, 3, 0, 1);
        program_ch(3, 3, 1, 1);
        program_ch(4, 0, 0, 1);
        clear_pass();
        build_expect(8'h1C);
        run_pass(8'h1C, -1, ok);
        check_pass("eop_timing", 8'h1C, ok, 0);
    endtask

    task automatic test_random;
        bit ok;
        logic [7:0] mask;
        gap_max  = 1;
        rdy_mode = 2;
        noise    = 1;
        for (int r = 0; r < 4; r++) begin
            mask = 8'($urandom_range(0, 255));
            for (int c = 0; c < 8; c++) program_ch(c, $urandom_range(0, 5), $urandom_range(0, 1), 1);
            clear_pass();
            build_expect(mask);
            run_pass(mask, -1, ok);
            check_pass("random", mask, ok, 0);
        end
        gap_max  = 0;
        rdy_mode = 0;
        noise    = 0;
    endtask

    task automatic test_timeout;
        bit ok;
        program_ch(3, 2, 2, 1);
        program_ch(4, 3, 0, 1);
        clear_pass();
        build_expect(8'h18);
        run_pass(8'h18, -1, ok);
        check_pass("timeout", 8'h18, ok, 1);
        n_checks++;
        if (!to_seen || to_cyc - sop_cyc[3] < TIMEOUT || to_cyc - sop_cyc[3] > TIMEOUT + 3)
            $display("FAIL timeout_cycle: got %0d cycles after rd_sop, need %0d..%0d", to_cyc - sop_cyc[3], TIMEOUT, TIMEOUT + 3);
        else n_pass++;
    endtask

    task automatic test_reset_mid_pass;
        bit ok = 0;
        gap_max = 1;
        program_ch(0, 4, 0, 1);
        program_ch(1, 6, 0, 1);
        clear_pass();
        build_expect(8'h03);
        ch_en = 8'h03;
        @(negedge clk) save_finish = 1'b1;
        @(negedge clk) save_finish = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (sop_cnt >= 2) begin
                ok = 1;
                break;
            end
        end
        n_checks++;
        if (!ok) $display("FAIL midrst_reach_ch1: got %0d sops, need 2", sop_cnt); else n_pass++;
        repeat (2) @(negedge clk);
        sb_en = 0;
        resp_abort = 1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rd_sop, m_vld, busy, done, err_timeout, err_ovf, m_data, m_ch, m_sop, m_eop} !== '0)
            $display("FAIL midrst_outputs: got %h, need 0",
                     {rd_sop, m_vld, busy, done, err_timeout, err_ovf, m_data, m_ch, m_sop, m_eop});
        else n_pass++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        resp_abort = 0;
        rd_vld = '0;
        rd_eop = '0;
        sent_total = 0;
        popped_total = 0;
        sb_en = 1;
        gap_max = 0;
        program_ch(0, 3, 0, 1);
        program_ch(1, 2, 1, 1);
        clear_pass();
        build_expect(8'h03);
        run_pass(8'h03, -1, ok);
        check_pass("midrst_restart", 8'h03, ok, 0);
    endtask

    initial begin
        test_reset;
        test_all_channels;
        test_sparse_mask;
        test_backpressure;
        test_eop_timing;
        test_random;
        test_timeout;
        test_reset_mid_pass;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
